// File: rtl/debounce_bank_pkg.sv
// Shared debounce constants for the board's divider rate, so the top level
// and anything instantiating it agree on the default window lengths.
package debounce_bank_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_STABLE_CNT  = 200;
    localparam int DEF_HOLD_TICKS  = 0;

endpackage

// File: rtl/debounce_bank_channel.sv
// One button channel: synchroniser, stability counter, optional hold counter
// and registered rise/fall/hold pulses.
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic btn_in,
    output logic btn_state,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_hold,
    output logic change_next
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   state_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   s;
    logic                   accept;

    assign s = sync_reg[SYNC_STAGES-1];

    // The window completes on this tick: the new level is taken at the edge.
    assign accept      = sample_tick && (s != state_reg) && (cnt_reg == STABLE_LAST);
    assign change_next = accept;

    // Metastability shift register, runs every clock regardless of the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Stability window: any tick of agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            state_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            rise_reg <= accept && s;
            fall_reg <= accept && !s;
            if (sample_tick) begin
                if (s == state_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_reg <= s;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    generate
        if (HOLD_TICKS > 0) begin : g_hold
            localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_TICKS);
            localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);

            logic [CNT_W-1:0] hcnt_reg;
            logic             hold_reg;

            // Count held ticks after the rise; saturating gives one pulse per press.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hcnt_reg <= '0;
                    hold_reg <= 1'b0;
                end else begin
                    hold_reg <= 1'b0;
                    if (!state_reg) begin
                        hcnt_reg <= '0;
                    end else if (sample_tick && (hcnt_reg < HOLD_LIM)) begin
                        hcnt_reg <= hcnt_reg + 1'b1;
                        hold_reg <= (hcnt_reg == HOLD_LAST);
                    end
                end
            end

            assign btn_hold = hold_reg;
        end else begin : g_no_hold
            assign btn_hold = 1'b0;
        end
    endgenerate

    assign btn_state = state_reg;
    assign btn_rise  = rise_reg;
    assign btn_fall  = fall_reg;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: N_CH independent channels plus a
// registered "something changed" flag for the counter control logic.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int STABLE_CNT  = DEF_STABLE_CNT,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_tick,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_hold,
    output logic            any_change
);

    generate
        if (N_CH < 1 || SYNC_STAGES < 2 || CNT_W < 1 ||
            STABLE_CNT < 1 || STABLE_CNT > (2**CNT_W) - 1 ||
            HOLD_TICKS < 0 || HOLD_TICKS > (2**CNT_W) - 1) begin : g_bad_params
            $error("debounce_bank: illegal parameter combination");
        end
    endgenerate

    logic [N_CH-1:0] change_next;
    logic            any_change_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES(SYNC_STAGES),
                .CNT_W      (CNT_W),
                .STABLE_CNT (STABLE_CNT),
                .HOLD_TICKS (HOLD_TICKS)
            ) u_channel (
                .clk        (clk),
                .rst        (rst),
                .sample_tick(sample_tick),
                .btn_in     (btn_in[gi]),
                .btn_state  (btn_state[gi]),
                .btn_rise   (btn_rise[gi]),
                .btn_fall   (btn_fall[gi]),
                .btn_hold   (btn_hold[gi]),
                .change_next(change_next[gi])
            );
        end
    endgenerate

    // Registered from the same terms as the pulses so it lines up with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_change_reg <= 1'b0;
        end else begin
            any_change_reg <= |change_next;
        end
    end

    assign any_change = any_change_reg;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed steps plus random traffic, compared every
// cycle against a behavioural model of the debounce rules.
module tb_debounce_bank;
    import debounce_bank_pkg::*;

    localparam int N  = 4;
    localparam int SS = DEF_SYNC_STAGES;
    localparam int CW = 8;
    localparam int SC = 4;
    localparam int HT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample_tick;
    logic [N-1:0] btn_in;

    logic [N-1:0] h_state, h_rise, h_fall, h_hold;
    logic         h_any;
    logic [N-1:0] n_state, n_rise, n_fall, n_hold;
    logic         n_any;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(N), .SYNC_STAGES(SS), .CNT_W(CW), .STABLE_CNT(SC), .HOLD_TICKS(HT)) dut_h (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .btn_in(btn_in),
        .btn_state(h_state), .btn_rise(h_rise), .btn_fall(h_fall), .btn_hold(h_hold),
        .any_change(h_any)
    );

    debounce_bank #(.N_CH(N), .SYNC_STAGES(SS), .CNT_W(CW), .STABLE_CNT(SC), .HOLD_TICKS(0)) dut_n (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .btn_in(btn_in),
        .btn_state(n_state), .btn_rise(n_rise), .btn_fall(n_fall), .btn_hold(n_hold),
        .any_change(n_any)
    );

    // Reference model state
    bit m_hist [N][SS];
    bit m_state[N];
    int m_run  [N];
    int m_held [N];
    bit m_rise [N];
    bit m_fall [N];
    bit m_hold [N];

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int rise_seen[N];
    int fall_seen[N];
    int hold_seen[N];
    int rise_cyc [N];
    int hold_cyc [N];

    task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc_n, obs, exp);
        end
    endtask

    // Apply the debounce rules for one clock edge using pre-edge inputs.
    task automatic model_edge();
        for (int ch = 0; ch < N; ch++) begin
            bit s;
            bit st_old;
            s      = m_hist[ch][SS-1];
            st_old = m_state[ch];
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            m_hold[ch] = 1'b0;
            if (rst) begin
                for (int k = 0; k < SS; k++) m_hist[ch][k] = 1'b0;
                m_state[ch] = 1'b0;
                m_run[ch]   = 0;
                m_held[ch]  = 0;
            end else begin
                for (int k = SS - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
                m_hist[ch][0] = btn_in[ch];
                if (!st_old) begin
                    m_held[ch] = 0;
                end else if (sample_tick && m_held[ch] < HT) begin
                    m_held[ch]++;
                    if (m_held[ch] == HT) m_hold[ch] = 1'b1;
                end
                if (sample_tick) begin
                    if (s == st_old) begin
                        m_run[ch] = 0;
                    end else begin
                        m_run[ch]++;
                        if (m_run[ch] == SC) begin
                            m_state[ch] = s;
                            m_run[ch]   = 0;
                            m_rise[ch]  = s;
                            m_fall[ch]  = !s;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: advance model, then compare every output just after the edge.
    task automatic cyc();
        logic [N-1:0] e_state, e_rise, e_fall, e_hold;
        @(posedge clk);
        model_edge();
        cyc_n++;
        #1;
        for (int ch = 0; ch < N; ch++) begin
            e_state[ch] = m_state[ch];
            e_rise[ch]  = m_rise[ch];
            e_fall[ch]  = m_fall[ch];
            e_hold[ch]  = m_hold[ch];
            if (h_rise[ch]) begin rise_seen[ch]++; rise_cyc[ch] = cyc_n; end
            if (h_fall[ch]) fall_seen[ch]++;
            if (h_hold[ch]) begin hold_seen[ch]++; hold_cyc[ch] = cyc_n; end
        end
        check_vec("state", h_state, e_state);
        check_vec("rise",  h_rise,  e_rise);
        check_vec("fall",  h_fall,  e_fall);
        check_vec("hold",  h_hold,  e_hold);
        check_int("any_change", int'(h_any), int'(|(e_rise | e_fall)));
        check_vec("nohold_state", n_state, e_state);
        check_vec("nohold_hold",  n_hold,  '0);
        check_int("nohold_any", int'(n_any), int'(|(e_rise | e_fall)));
    endtask

    task automatic run(input int n, input int period);
        repeat (n) begin
            sample_tick = (period <= 1) ? 1'b1 : ((cyc_n % period) == 0);
            cyc();
        end
    endtask

    task automatic press_latency(input int ch, input string tag, input int exp_lat);
        int lat;
        lat = 0;
        sample_tick = 1'b1;
        btn_in[ch] = 1'b1;
        while (!h_state[ch] && lat < 30) begin
            cyc();
            lat++;
        end
        check_int(tag, lat, exp_lat);
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < N; ch++) begin
            rise_seen[ch] = 0; fall_seen[ch] = 0; hold_seen[ch] = 0;
            rise_cyc[ch] = -1; hold_cyc[ch] = -1;
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_in = '0;
        sample_tick = 1'b1;
        clear_counts();
        for (int ch = 0; ch < N; ch++) begin
            for (int k = 0; k < SS; k++) m_hist[ch][k] = 1'b0;
            m_state[ch] = 1'b0; m_run[ch] = 0; m_held[ch] = 0;
        end

        // Reset state
        repeat (3) cyc();
        rst = 1'b0;
        check_vec("reset_state", h_state, '0);

        // Clean press: latency SYNC_STAGES+STABLE_CNT
        clear_counts();
        press_latency(0, "t1_latency", SS + SC);
        check_int("t1_rise_once", rise_seen[0], 1);
        run(5, 1);
        check_int("t1_no_fall", fall_seen[0], 0);

        // Glitch of 3 cycles is rejected, full window afterwards
        btn_in[1] = 1'b1;
        run(3, 1);
        btn_in[1] = 1'b0;
        run(8, 1);
        check_int("t2_glitch_state", int'(h_state[1]), 0);
        check_int("t2_glitch_rise", rise_seen[1], 0);
        press_latency(1, "t2_relatency", SS + SC);

        // Tick gating: one tick every 10 cycles, 1-cycle pulse
        btn_in = '0;
        run(30, 1);
        clear_counts();
        btn_in[2] = 1'b1;
        run(80, 10);
        check_int("t3_state", int'(h_state[2]), 1);
        check_int("t3_rise_once", rise_seen[2], 1);

        // Release and hold detection, twice
        btn_in = '0;
        run(20, 1);
        clear_counts();
        btn_in[3] = 1'b1;
        run(30, 1);
        check_int("t4_hold_once", hold_seen[3], 1);
        check_int("t4_hold_delay", hold_cyc[3] - rise_cyc[3], HT);
        btn_in[3] = 1'b0;
        run(15, 1);
        check_int("t4_fall_once", fall_seen[3], 1);
        btn_in[3] = 1'b1;
        run(30, 1);
        check_int("t4_hold_second", hold_seen[3], 2);

        // Multi-channel: ch0/ch2 together, ch1 bouncing, reset mid-window on ch3
        btn_in = '0;
        run(20, 1);
        clear_counts();
        btn_in[0] = 1'b1;
        btn_in[2] = 1'b1;
        repeat (12) begin
            btn_in[1] = ~btn_in[1];
            run(1, 1);
        end
        check_int("t5_ch0_rise_cycle", rise_cyc[0], rise_cyc[2]);
        check_int("t5_ch0_rose", rise_seen[0], 1);
        check_int("t5_ch1_quiet", rise_seen[1], 0);
        btn_in[1] = 1'b0;
        btn_in[3] = 1'b1;
        run(4, 1);
        rst = 1'b1;
        run(1, 1);
        rst = 1'b0;
        check_vec("t5_reset_state", h_state, '0);
        check_vec("t5_reset_rise", h_rise, '0);
        press_latency(3, "t5_ch3_full_window", SS + SC);

        // Random traffic with random tick density and occasional reset
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 7) == 0) btn_in[ch] = ~btn_in[ch];
            end
            sample_tick = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
